// File: rtl/pmem_rd_pkg.sv
// Shared types and defaults for the pmem stream reader.
// Contents:
//   PMEM_ADDR_W / PMEM_DATA_W  default geometry of the 16384x128 macro
//   len_t                      word count type (0..2^ADDR_W inclusive)
//   state_e                    command FSM states
package pmem_rd_pkg;

    localparam int PMEM_ADDR_W = 14;
    localparam int PMEM_DATA_W = 128;

    typedef logic [PMEM_ADDR_W:0] len_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/pmem_rd_fifo.sv
// Small synchronous skid FIFO holding SRAM read words plus their last flag.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push_i, wdata_i     write strobe and entry
//   pop_i               read strobe (head advances)
//   rdata_o             head entry (valid while !empty_o)
//   full_o, empty_o     occupancy flags
//   count_o             number of stored entries
// Push and pop in the same cycle are allowed at any occupancy, including full.
module pmem_rd_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; entries are only observed after being written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/pmem_stream_reader.sv
// Read-side initiator for the single-port pmem SRAM macro (CEN/WEN active-low,
// 1-cycle registered read). On start it reads len consecutive words from
// base_addr (address wraps modulo 2^ADDR_W) and streams them on a valid/ready
// port; a skid FIFO absorbs read latency and backpressure.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, base_addr, len      command, sampled only in IDLE
//   busy, done                 command status; done is a 1-cycle pulse
//   mem_CEN/WEN/A/D, mem_Q     SRAM interface (read-only use)
//   out_data/valid/ready/last  output stream
//   checksum                   XOR of all handshaken beats of the command
//                              (present only when PMEM_RD_CHECKSUM_EN is defined)
// Build option: `define PMEM_RD_CHECKSUM_EN adds the checksum output.
module pmem_stream_reader
    import pmem_rd_pkg::*;
#(
    parameter int ADDR_W     = PMEM_ADDR_W,
    parameter int DATA_W     = PMEM_DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              mem_CEN,
    output logic              mem_WEN,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_D,
    input  logic [DATA_W-1:0] mem_Q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef PMEM_RD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              issue;

    logic [DATA_W:0]   fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop;
    logic [CNT_W:0]    need;

    assign pop = out_valid & out_ready;

    // Slots committed at the end of this cycle before any new issue:
    // stored words plus the word landing from the SRAM, minus the one leaving.
    assign need = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        issue           = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = len;
                    state_d     = (len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                // The full/pop term is implied by the occupancy sum; it is kept
                // as a direct guard against an unpaired push into a full FIFO.
                if (remaining_q != '0 && need < (CNT_W + 1)'(FIFO_DEPTH) &&
                    !(fifo_full && !pop)) begin
                    issue           = 1'b1;
                    addr_d          = addr_q + 1'b1;
                    remaining_d     = remaining_q - 1'b1;
                    inflight_d      = 1'b1;
                    inflight_last_d = (remaining_q == (ADDR_W + 1)'(1));
                end
                // Leave as soon as the final beat handshakes so done follows it
                // by exactly one cycle.
                if (remaining_q == '0 && !inflight_q &&
                    (fifo_empty || (fifo_count == CNT_W'(1) && pop))) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // mem_Q is valid the cycle after issue, which is exactly when inflight_q is set.
    pmem_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (inflight_q),
        .wdata_i ({inflight_last_q, mem_Q}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign mem_CEN   = ~issue;
    assign mem_WEN   = 1'b1;
    assign mem_A     = addr_q;
    assign mem_D     = '0;
    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_rdata[DATA_W-1:0];
    assign out_last  = ~fifo_empty & fifo_rdata[DATA_W];

`ifdef PMEM_RD_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (state_q == IDLE && start) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q ^ out_data;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
